// File: rtl/ddr_cmd_pkg.sv
// rtl/ddr_cmd_pkg.sv - DDR4 command bit indices, CA pin encodings and command vector type
package ddr_cmd_pkg;

   localparam int CMD_W = 19;

   // One-hot command bit positions, MSB first
   localparam int CMD_ACT  = 18;
   localparam int CMD_BST  = 17;
   localparam int CMD_CFG  = 16;
   localparam int CMD_CKEH = 15;
   localparam int CMD_CKEL = 14;
   localparam int CMD_DPD  = 13;
   localparam int CMD_DPDX = 12;
   localparam int CMD_MRR  = 11;
   localparam int CMD_MRW  = 10;
   localparam int CMD_PD   = 9;
   localparam int CMD_PDX  = 8;
   localparam int CMD_PR   = 7;
   localparam int CMD_PRA  = 6;
   localparam int CMD_RD   = 5;
   localparam int CMD_RDA  = 4;
   localparam int CMD_REF  = 3;
   localparam int CMD_SRF  = 2;
   localparam int CMD_WR   = 1;
   localparam int CMD_WRA  = 0;

   typedef logic [CMD_W-1:0] cmd_t;

   // {ras_n, cas_n, we_n} encodings with act_n high
   localparam logic [2:0] RCW_MRW  = 3'b000;
   localparam logic [2:0] RCW_REF  = 3'b001;
   localparam logic [2:0] RCW_PR   = 3'b010;
   localparam logic [2:0] RCW_RSVD = 3'b011;
   localparam logic [2:0] RCW_WR   = 3'b100;
   localparam logic [2:0] RCW_RD   = 3'b101;
   localparam logic [2:0] RCW_ZQ   = 3'b110;
   localparam logic [2:0] RCW_NOP  = 3'b111;

   // Commands that target only the addressed bank; everything else is broadcast
   localparam cmd_t ADDR_MASK = cmd_t'((1 << CMD_ACT) | (1 << CMD_PR) | (1 << CMD_RD) |
                                       (1 << CMD_RDA) | (1 << CMD_WR) | (1 << CMD_WRA));
   // Column accesses
   localparam cmd_t RW_MASK   = cmd_t'((1 << CMD_RD) | (1 << CMD_RDA) | (1 << CMD_WR) | (1 << CMD_WRA));
   // Commands this front end never produces
   localparam cmd_t NEVER_MASK = cmd_t'((1 << CMD_BST) | (1 << CMD_DPD) | (1 << CMD_DPDX) | (1 << CMD_MRR));

endpackage

// File: rtl/ddr_bank_row_tracker.sv
// rtl/ddr_bank_row_tracker.sv - open flag and open-row register for one bank, with legality hints
module ddr_bank_row_tracker #(
   parameter int ROW_W = 17
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             act,
   input  logic             close,
   input  logic [ROW_W-1:0] row_in,
   output logic             bank_open,
   output logic [ROW_W-1:0] bank_row,
   output logic             act_illegal,
   output logic             access_illegal
);

   logic             open_q, open_d;
   logic [ROW_W-1:0] row_q, row_d;

   // ACT opens the bank and captures the row; a close keeps the last row visible
   always_comb begin
      open_d = open_q;
      row_d  = row_q;
      if (act) begin
         open_d = 1'b1;
         row_d  = row_in;
      end else if (close) begin
         open_d = 1'b0;
      end
   end

   // Per-bank state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         open_q <= 1'b0;
         row_q  <= '0;
      end else begin
         open_q <= open_d;
         row_q  <= row_d;
      end
   end

   assign bank_open      = open_q;
   assign bank_row       = row_q;
   assign act_illegal    = open_q;
   assign access_illegal = ~open_q;

endmodule

// File: rtl/ddr_cmd_decoder.sv
// rtl/ddr_cmd_decoder.sv - DDR4 CA decoder with bank steering and row tracking; optional checks under PROTOCOL_CHECK_EN
module ddr_cmd_decoder
   import ddr_cmd_pkg::*;
#(
   parameter int BGWIDTH   = 2,
   parameter int BAWIDTH   = 2,
   parameter int ADDRWIDTH = 17,
   parameter int ROWS      = 131072,
   parameter int COLS      = 1024,
   localparam int NBANKS   = 2 ** (BGWIDTH + BAWIDTH),
   localparam int ROW_W    = $clog2(ROWS),
   localparam int COL_W    = $clog2(COLS)
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cke,
   input  logic                      cs_n,
   input  logic                      act_n,
   input  logic                      ras_n_a16,
   input  logic                      cas_n_a15,
   input  logic                      we_n_a14,
   input  logic [ADDRWIDTH-1:0]      A,
   input  logic [BGWIDTH-1:0]        bg,
   input  logic [BAWIDTH-1:0]        ba,
   output logic [NBANKS*CMD_W-1:0]   bank_cmds,
   output logic [NBANKS*ROW_W-1:0]   bank_rows,
   output logic [COL_W-1:0]          column,
   output logic [NBANKS-1:0]         bank_open,
   output logic [2:0]                err
);

   localparam int BANK_W = BGWIDTH + BAWIDTH;

   logic                    cke_q, cke_d;
   logic [NBANKS*CMD_W-1:0] cmds_q, cmds_d;
   logic [COL_W-1:0]        column_q, column_d;
   logic [NBANKS-1:0]       bank_act, bank_close, act_ill, acc_ill;
   logic [BANK_W-1:0]       sel;
   logic [ROW_W-1:0]        act_row;
   logic [2:0]              viol;
   logic                    unused_a;
   cmd_t                    raw, cke_cmd, bus, addressed, broadcast, slice;

   assign sel      = {bg, ba};
   assign act_row  = ROW_W'({ras_n_a16, cas_n_a15, we_n_a14, A[13:0]});
   assign unused_a = ^A[ADDRWIDTH-1:14];

   // Decode the CA pins and the cke transition into command bits
   always_comb begin
      raw     = '0;
      cke_cmd = '0;
      if (!cs_n) begin
         if (!act_n) begin
            raw[CMD_ACT] = 1'b1;
         end else begin
            case ({ras_n_a16, cas_n_a15, we_n_a14})
               RCW_MRW: raw[CMD_MRW] = 1'b1;
               RCW_REF: if (cke_q && !cke) raw[CMD_SRF] = 1'b1;
                        else               raw[CMD_REF] = 1'b1;
               RCW_PR:  if (A[10]) raw[CMD_PRA] = 1'b1;
                        else       raw[CMD_PR]  = 1'b1;
               RCW_WR:  if (A[10]) raw[CMD_WRA] = 1'b1;
                        else       raw[CMD_WR]  = 1'b1;
               RCW_RD:  if (A[10]) raw[CMD_RDA] = 1'b1;
                        else       raw[CMD_RD]  = 1'b1;
               RCW_ZQ:  raw[CMD_CFG] = 1'b1;
               RCW_RSVD, RCW_NOP: ;
               default: ;
            endcase
         end
      end
      if (cke_q && !cke) begin
         cke_cmd[CMD_CKEL] = 1'b1;
         if (!(raw[CMD_REF] || raw[CMD_SRF])) cke_cmd[CMD_PD] = 1'b1;
      end
      if (!cke_q && cke) begin
         cke_cmd[CMD_CKEH] = 1'b1;
         cke_cmd[CMD_PDX]  = 1'b1;
      end
   end

`ifdef PROTOCOL_CHECK_EN
   logic [2:0] err_q, err_d;

   // Flag illegal bus commands against the current bank state; flags stick until reset
   always_comb begin
      viol    = '0;
      viol[0] = raw[CMD_ACT] & act_ill[sel];
      viol[1] = (|(raw & RW_MASK)) & acc_ill[sel];
      viol[2] = (raw[CMD_REF] | raw[CMD_SRF]) & (|bank_open);
      err_d   = err_q | viol;
   end

   // Sticky error register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= '0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`else
   logic unused_legality;
   assign viol            = '0;
   assign unused_legality = ^{act_ill, acc_ill};
   assign err             = '0;
`endif

   // Drop an illegal bus command, then steer the rest to the bank slices
   always_comb begin
      bus        = (|viol) ? '0 : raw;
      addressed  = bus & ADDR_MASK;
      broadcast  = (bus & ~ADDR_MASK & ~NEVER_MASK) | cke_cmd;
      column_d   = (|(bus & RW_MASK)) ? A[COL_W-1:0] : column_q;
      cke_d      = cke;
      cmds_d     = '0;
      bank_act   = '0;
      bank_close = '0;
      slice      = '0;
      for (int k = 0; k < NBANKS; k++) begin
         slice = broadcast | ((sel == BANK_W'(k)) ? addressed : '0);
         cmds_d[k*CMD_W +: CMD_W] = slice;
         bank_act[k]   = slice[CMD_ACT];
         bank_close[k] = slice[CMD_PR] | slice[CMD_PRA] | slice[CMD_RDA] | slice[CMD_WRA];
      end
   end

   // Output and cke history registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmds_q   <= '0;
         column_q <= '0;
         cke_q    <= 1'b1;
      end else begin
         cmds_q   <= cmds_d;
         column_q <= column_d;
         cke_q    <= cke_d;
      end
   end

   for (genvar k = 0; k < NBANKS; k++) begin : g_bank
      ddr_bank_row_tracker #(.ROW_W(ROW_W)) u_trk (
         .clk            (clk),
         .rst            (rst),
         .act            (bank_act[k]),
         .close          (bank_close[k]),
         .row_in         (act_row),
         .bank_open      (bank_open[k]),
         .bank_row       (bank_rows[k*ROW_W +: ROW_W]),
         .act_illegal    (act_ill[k]),
         .access_illegal (acc_ill[k])
      );
   end

   assign bank_cmds = cmds_q;
   assign column    = column_q;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// tb/tb_ddr_cmd_decoder.sv - randomized and directed self-checking bench for ddr_cmd_decoder
module tb_ddr_cmd_decoder;

   localparam int NB = 16;
   localparam int RW = 17;
   localparam int CW = 10;

   localparam int B_ACT = 18, B_CFG = 16, B_CKEH = 15, B_CKEL = 14, B_MRW = 10, B_PD = 9, B_PDX = 8;
   localparam int B_PR = 7, B_PRA = 6, B_RD = 5, B_RDA = 4, B_REF = 3, B_SRF = 2, B_WR = 1, B_WRA = 0;

   logic clk = 1'b0;
   logic rst, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
   logic [16:0] A;
   logic [1:0]  bg, ba;
   logic [NB*19-1:0] bank_cmds;
   logic [NB*RW-1:0] bank_rows;
   logic [CW-1:0]    column;
   logic [NB-1:0]    bank_open;
   logic [2:0]       err;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [18:0] m_cmds [NB];
   logic [16:0] m_rows [NB];
   logic [NB-1:0] m_open;
   logic [9:0]  m_col;
   logic        m_cke_prev;
   logic [2:0]  m_err;

   always #5 clk = ~clk;

   ddr_cmd_decoder dut (
      .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n),
      .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
      .A(A), .bg(bg), .ba(ba), .bank_cmds(bank_cmds), .bank_rows(bank_rows),
      .column(column), .bank_open(bank_open), .err(err)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NB*19-1:0] all_slices(input logic [18:0] v);
      logic [NB*19-1:0] r;
      for (int k = 0; k < NB; k++) r[k*19 +: 19] = v;
      return r;
   endfunction

   function automatic bit is_addressed(input int b);
      return (b == B_ACT) || (b == B_PR) || (b == B_RD) || (b == B_RDA) || (b == B_WR) || (b == B_WRA);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NB; k++) begin
         m_cmds[k] = '0;
         m_rows[k] = '0;
      end
      m_open = '0;
      m_col = '0;
      m_cke_prev = 1'b1;
      m_err = '0;
   endtask

   // advance the model by one clock using the current pin values
   task automatic model_step();
      int sel;
      int bus;
      logic [18:0] side;
      logic [2:0] viol;
      sel = {bg, ba};
      bus = -1;
      side = '0;
      viol = '0;
      if (!cs_n) begin
         if (!act_n) bus = B_ACT;
         else begin
            case ({ras_n_a16, cas_n_a15, we_n_a14})
               3'b000: bus = B_MRW;
               3'b001: bus = (m_cke_prev && !cke) ? B_SRF : B_REF;
               3'b010: bus = A[10] ? B_PRA : B_PR;
               3'b100: bus = A[10] ? B_WRA : B_WR;
               3'b101: bus = A[10] ? B_RDA : B_RD;
               3'b110: bus = B_CFG;
               default: bus = -1;
            endcase
         end
      end
      if (m_cke_prev && !cke) begin
         side[B_CKEL] = 1'b1;
         if (bus != B_REF && bus != B_SRF) side[B_PD] = 1'b1;
      end
      if (!m_cke_prev && cke) begin
         side[B_CKEH] = 1'b1;
         side[B_PDX] = 1'b1;
      end
`ifdef PROTOCOL_CHECK_EN
      if (bus == B_ACT && m_open[sel]) viol[0] = 1'b1;
      if ((bus == B_RD || bus == B_RDA || bus == B_WR || bus == B_WRA) && !m_open[sel]) viol[1] = 1'b1;
      if ((bus == B_REF || bus == B_SRF) && m_open != 0) viol[2] = 1'b1;
      if (viol != 0) bus = -1;
      m_err = m_err | viol;
`endif
      for (int k = 0; k < NB; k++) begin
         m_cmds[k] = side;
         if (bus >= 0 && (!is_addressed(bus) || k == sel)) m_cmds[k][bus] = 1'b1;
      end
      if (bus == B_ACT) begin
         m_open[sel] = 1'b1;
         m_rows[sel] = {ras_n_a16, cas_n_a15, we_n_a14, A[13:0]};
      end
      if (bus == B_PR || bus == B_RDA || bus == B_WRA) m_open[sel] = 1'b0;
      if (bus == B_PRA) m_open = '0;
      if (bus == B_RD || bus == B_RDA || bus == B_WR || bus == B_WRA) m_col = A[9:0];
      m_cke_prev = cke;
   endtask

   task automatic compare_all(input string tag);
      logic [NB*19-1:0] ec;
      logic [NB*RW-1:0] er;
      for (int k = 0; k < NB; k++) begin
         ec[k*19 +: 19] = m_cmds[k];
         er[k*RW +: RW] = m_rows[k];
      end
      check({tag, ".cmds"}, bank_cmds, ec);
      check({tag, ".rows"}, bank_rows, er);
      check({tag, ".open"}, bank_open, m_open);
      check({tag, ".col"}, column, m_col);
      check({tag, ".err"}, err, m_err);
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic drive(input logic cs, input logic act, input logic [2:0] rcw, input logic [16:0] addr,
                        input logic [1:0] bgv, input logic [1:0] bav, input logic ckev);
      cs_n = cs;
      act_n = act;
      {ras_n_a16, cas_n_a15, we_n_a14} = rcw;
      A = addr;
      bg = bgv;
      ba = bav;
      cke = ckev;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 1'b1, 3'b111, 17'h0, 2'd0, 2'd0, 1'b1);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      check("reset.cmds_zero", bank_cmds, '0);
      rst = 1'b0;

      // ACT bank 6, row 0x11234
      drive(1'b0, 1'b0, 3'b100, 17'h1234, 2'd1, 2'd2, 1'b1);
      cycle("act6");
      check("act6.slice", bank_cmds[6*19 +: 19], 19'h40000);
      check("act6.row", bank_rows[6*RW +: RW], 17'h11234);
      check("act6.open", bank_open[6], 1'b1);

      // RDA to bank 6, column 0x07C
      drive(1'b0, 1'b1, 3'b101, 17'h047C, 2'd1, 2'd2, 1'b1);
      cycle("rda6");
      check("rda6.slice", bank_cmds[6*19 +: 19], 19'h00010);
      check("rda6.col", column, 10'h07C);
      check("rda6.open", bank_open[6], 1'b0);

      // open banks 0 and 3, then PRA
      drive(1'b0, 1'b0, 3'b000, 17'h0011, 2'd0, 2'd0, 1'b1);
      cycle("act0");
      drive(1'b0, 1'b0, 3'b010, 17'h0022, 2'd0, 2'd3, 1'b1);
      cycle("act3");
      check("act3.open", bank_open, 16'h0009);
      drive(1'b0, 1'b1, 3'b010, 17'h0400, 2'd0, 2'd0, 1'b1);
      cycle("pra");
      check("pra.cmds", bank_cmds, all_slices(19'h00040));
      check("pra.open", bank_open, 16'h0000);

      // REF with cke falling -> SRF + CKEL, no PD; then cke rising -> CKEH + PDX
      drive(1'b0, 1'b1, 3'b001, 17'h0, 2'd0, 2'd0, 1'b0);
      cycle("srf");
      check("srf.cmds", bank_cmds, all_slices(19'h04004));
      drive(1'b1, 1'b1, 3'b111, 17'h0, 2'd0, 2'd0, 1'b1);
      cycle("ckeh");
      check("ckeh.cmds", bank_cmds, all_slices(19'h08100));

      // WR to closed bank 2
      drive(1'b0, 1'b1, 3'b100, 17'h0005, 2'd0, 2'd2, 1'b1);
      cycle("wr2");
`ifdef PROTOCOL_CHECK_EN
      check("wr2.cmds", bank_cmds, '0);
      check("wr2.err1", err[1], 1'b1);
`else
      check("wr2.slice", bank_cmds[2*19 +: 19], 19'h00002);
      check("wr2.err", err, 3'b000);
`endif

      // randomized stream
      for (int i = 0; i < 1500; i++) begin
         cs_n = ($urandom_range(0, 4) == 0);
         act_n = ($urandom_range(0, 3) != 0);
         {ras_n_a16, cas_n_a15, we_n_a14} = 3'($urandom_range(0, 7));
         A = 17'($urandom);
         bg = 2'($urandom_range(0, 3));
         ba = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) cke = ~cke;
         cycle("rand");
      end

      // back-to-back ACT/RD, then asynchronous reset mid-cycle
      drive(1'b1, 1'b1, 3'b111, 17'h0, 2'd0, 2'd0, 1'b1);
      cycle("idle");
      drive(1'b0, 1'b1, 3'b010, 17'h0400, 2'd0, 2'd0, 1'b1);
      cycle("pre_pra");
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 3'b000, 17'(i + 1), 2'd1, 2'd1, 1'b1);
         cycle("stream_act");
         drive(1'b0, 1'b1, 3'b101, 17'h0003, 2'd1, 2'd1, 1'b1);
         cycle("stream_rd");
      end
      drive(1'b0, 1'b0, 3'b000, 17'h0042, 2'd1, 2'd1, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("arst.cmds", bank_cmds, '0);
      check("arst.rows", bank_rows, '0);
      check("arst.open", bank_open, '0);
      check("arst.col", column, '0);
      check("arst.err", err, '0);
      model_reset();
      @(posedge clk);
      #1;
      compare_all("arst_hold");
      rst = 1'b0;

      // first ACT after release
      drive(1'b0, 1'b0, 3'b011, 17'h0ABC, 2'd0, 2'd1, 1'b1);
      cycle("post_act");
      check("post_act.slice", bank_cmds[1*19 +: 19], 19'h40000);
      check("post_act.row", bank_rows[1*RW +: RW], 17'h0CABC);
      drive(1'b1, 1'b1, 3'b111, 17'h0, 2'd0, 2'd0, 1'b1);
      cycle("tail");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
